// File: rtl/mem_responder.sv
// Pipelined 16-bit word memory responder: single-cycle writes, fixed LAT-cycle reads.
// Optional feature macro: MEM_RANGE_CHK_EN (flags addresses beyond the array via err).
module mem_responder #(
   parameter int ADDR_W = 12,
   parameter int LAT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        err
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Array is never reset; contents rely on the zeroed power-up state of the storage.
   logic [15:0]            r_mem [DEPTH];
   logic [LAT-1:0]         r_vld;
   logic [LAT-1:0][15:0]   r_dat;

   logic [ADDR_W-1:0]      w_idx;
   logic                   w_rd;
   logic                   w_wr_ok;
   logic                   w_oor;
   logic [15:0]            w_unused_addr;

   assign w_idx         = addr[ADDR_W:1];
   assign w_unused_addr = addr;

`ifdef MEM_RANGE_CHK_EN
   logic [LAT-1:0] r_oor;
   logic           r_werr;

   generate
      if (ADDR_W >= 15) begin : g_no_oor
         assign w_oor = 1'b0;
      end else begin : g_oor
         assign w_oor = |addr[15:ADDR_W+1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_oor  <= '0;
         r_werr <= 1'b0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) r_oor[i] <= r_oor[i-1];
         r_oor[0] <= w_rd & w_oor;
         r_werr   <= enable & wr & w_oor;
      end
   end

   assign err = (r_vld[LAT-1] & r_oor[LAT-1]) | r_werr;
`else
   assign w_oor = 1'b0;
   assign err   = 1'b0;
`endif

   assign w_rd    = enable & ~wr;
   assign w_wr_ok = enable & wr & ~w_oor;

   // Writes are suppressed while rst is high so a write on the reset edge is dropped.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) r_mem[w_idx] <= data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) r_vld[i] <= r_vld[i-1];
         r_vld[0] <= w_rd;
      end
   end

   // Data is sampled at acceptance, so later writes cannot disturb an in-flight read.
   always_ff @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) r_dat[i] <= r_dat[i-1];
      r_dat[0] <= w_oor ? 16'h0000 : r_mem[w_idx];
   end

   assign data_valid = r_vld[LAT-1];
   assign data_out   = r_vld[LAT-1] ? r_dat[LAT-1] : 16'h0000;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: word-address width; array holds 2^ADDR_W 16-bit words; legal range 8..15.
REQ-002 SHALL have parameter LAT, default 4: read latency in cycles; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  request valid this cycle.
REQ-006 wr  input  1  request type when enable=1: 1 = write, 0 = read.
REQ-007 addr  input  16  byte address; addr[0] ignored; word index = addr[ADDR_W:1].
REQ-008 data_in  input  16  write data, sampled with a write request.
REQ-009 data_out  output  16  read data, valid only while data_valid=1, otherwise 16'h0000.
REQ-010 data_valid  output  1  one-cycle pulse per completed read.
REQ-011 err  output  1  range-error flag, qualified per REQ-026/REQ-027.

Function
REQ-012 SHALL accept one request on every rising edge where enable=1; the block never stalls or back-pressures.
REQ-013 SHALL ignore wr, addr and data_in on edges where enable=0.
REQ-014 Write: data_in SHALL be stored at the word index on the accepting edge; a write never raises data_valid.
REQ-015 Read: array contents SHALL be sampled on the accepting edge, then delivered through a LAT-deep valid/data shift pipeline.
REQ-016 A read accepted at edge N SHALL produce data_valid=1 and data_out in the cycle after edge N+LAT-1, i.e. LAT cycles after acceptance.
REQ-017 Reads SHALL complete in issue order; back-to-back reads SHALL produce back-to-back data_valid pulses with no bubbles.
REQ-018 Read-after-write to the same word accepted on a later edge SHALL return the new data.
REQ-019 A write accepted after a read to the same word SHALL NOT alter that read's in-flight data.
REQ-020 Interleaved read/write streams SHALL keep each read's slot in the pipeline; write slots appear as bubbles (data_valid=0).
REQ-021 Unwritten words SHALL read as 16'h0000 after power-up initialisation; reset does not clear the array.

Reset
REQ-022 While rst=1, all pipeline valid bits SHALL clear immediately, and data_out=16'h0000, data_valid=0, err=0.
REQ-023 Reads in flight when rst asserts SHALL be discarded and never produce data_valid.
REQ-024 Array contents SHALL be unaffected by rst; a write on the edge where rst is asserted SHALL be dropped.
REQ-025 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 With macro MEM_RANGE_CHK_EN defined, any request with addr[15:ADDR_W+1] nonzero SHALL be out of range:
- Out-of-range write: dropped, and err SHALL pulse for one cycle on the following cycle.
- Out-of-range read: travels the pipeline normally; at delivery data_valid=1, data_out=16'h0000, err=1.
- Concurrent write-error and read-error pulses SHALL OR into one err pulse.
- When ADDR_W=15, no address is out of range.
REQ-027 Without MEM_RANGE_CHK_EN, addr[15:ADDR_W+1] SHALL be ignored (addresses alias) and err SHALL be tied to 0.

Verification
REQ-028 Write addr=16'h0010, data_in=16'hBEEF; next cycle read 16'h0011 -> with LAT=4, data_valid pulses 4 cycles after the read with data_out=16'hBEEF.
REQ-029 Four consecutive reads of words 0..3, preloaded with 1,2,3,4 -> four consecutive data_valid cycles returning 1,2,3,4 in order.
REQ-030 Read word 5 (value 16'h1111), then write word 5 = 16'h2222 next cycle, then read word 5 -> returns 16'h1111 then 16'h2222.
REQ-031 Issue reads on 3 consecutive edges, then assert rst for 1 cycle before any completes -> no data_valid pulse; a read issued after reset returns correctly in LAT cycles.
REQ-032 With MEM_RANGE_CHK_EN and ADDR_W=12, read addr=16'h4000 -> data_valid=1, err=1, data_out=0; write 16'h4000 = 16'hFFFF -> err pulses 1 cycle, word 0 is unchanged.
REQ-033 Without MEM_RANGE_CHK_EN and ADDR_W=12, write 16'h2002 = 16'hA5A5, then read 16'h0002 -> 16'hA5A5 returned, err stays 0.
